// File: rtl/addr_router.sv
// addr_router: decodes a request address against programmable windows, forwards
// it to one slave with a one-hot select and returns an ack/timeout response.
module addr_router #(
  parameter int ADDR_W = 32,
  parameter int N_REGIONS = 2,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h0000_0000, 32'h0000_2B10},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LAST = {32'h0000_FFFF, 32'h0000_2F0F},
  parameter int TIMEOUT = 15,
  localparam int IW = N_REGIONS > 1 ? $clog2(N_REGIONS) : 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 req_ready,
  output logic [N_REGIONS-1:0] sel,
  output logic [IW-1:0]        region_idx,
  output logic                 slv_valid,
  input  logic [N_REGIONS-1:0] slv_ack,
  output logic                 resp_valid,
  output logic                 resp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N_REGIONS-1:0] sel_n;
  logic [IW-1:0] idx_n, hit_idx;
  logic err, err_n, hit;
  // Scan from the top down so the lowest overlapping index wins.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--)
      if (req_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] && req_addr <= REGION_LAST[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = sel;
    idx_n = region_idx;
    err_n = err;
    case (state)
      IDLE: if (req_valid) begin
        state_n = hit ? BUSY : RESP;
        sel_n = '0;
        sel_n[hit_idx] = hit;
        idx_n = hit ? hit_idx : region_idx;
        cnt_n = '0;
        err_n = !hit;
      end
      BUSY: if (slv_ack[region_idx]) begin
        state_n = RESP;
        err_n = 1'b0;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state_n = RESP;
        err_n = 1'b1;
      end else
        cnt_n = cnt + 1'b1;
      RESP: begin
        state_n = IDLE;
        sel_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sel <= '0;
      region_idx <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sel <= sel_n;
      region_idx <= idx_n;
      err <= err_n;
    end
  assign req_ready = state == IDLE;
  assign slv_valid = state == BUSY;
  assign resp_valid = state == RESP;
  assign resp_err = resp_valid & err;
endmodule

// File: tb/tb_addr_router.sv
// tb_addr_router: directed checks of decode, ack/timeout, reset and back-to-back
// on the default router and a 4-region, TIMEOUT=1 variant.
module tb_addr_router;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, slv_valid, resp_valid, resp_err, region_idx;
  logic [31:0] req_addr = '0;
  logic [1:0] sel, slv_ack = '0;
  logic r2_valid = 1'b0, r2_ready, r2_slv_valid, r2_resp_valid, r2_resp_err;
  logic [31:0] r2_addr = '0;
  logic [3:0] r2_sel, r2_ack = '0;
  logic [1:0] r2_idx;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  addr_router dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .sel(sel), .region_idx(region_idx), .slv_valid(slv_valid), .slv_ack(slv_ack),
    .resp_valid(resp_valid), .resp_err(resp_err)
  );

  addr_router #(
    .N_REGIONS(4),
    .REGION_BASE({32'h0000_0000, 32'h0000_1800, 32'h0000_1000, 32'h0000_5000}),
    .REGION_LAST({32'h0000_FFFF, 32'h0000_27FF, 32'h0000_1FFF, 32'h0000_5FFF}),
    .TIMEOUT(1)
  ) dut4 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_addr(r2_addr), .req_ready(r2_ready),
    .sel(r2_sel), .region_idx(r2_idx), .slv_valid(r2_slv_valid), .slv_ack(r2_ack),
    .resp_valid(r2_resp_valid), .resp_err(r2_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input int ack_c, input logic [1:0] ack_v,
                     input logic [1:0] e_sel, input logic e_idx, input int e_resp, input logic e_err);
    int sv_cnt = 0, rc = -1;
    req_addr = a;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_addr = 32'h0001_0000;
    for (int c = 1; c <= 40 && rc < 0; c++) begin
      slv_ack = (ack_c > 0 && c >= ack_c) ? ack_v : 2'b00;
      if (c == 1) begin
        check({tag, "_sel"}, 32'(sel), 32'(e_sel));
        check({tag, "_slv1"}, 32'(slv_valid), 32'(e_sel != 2'b00));
        if (e_sel != 2'b00) check({tag, "_idx"}, 32'(region_idx), 32'(e_idx));
      end
      if (slv_valid) sv_cnt++;
      if (resp_valid) begin
        rc = c;
        check({tag, "_err"}, 32'(resp_err), 32'(e_err));
        check({tag, "_selheld"}, 32'(sel), 32'(e_sel));
      end
      step();
    end
    slv_ack = 2'b00;
    check({tag, "_respcyc"}, rc, e_resp);
    check({tag, "_slvcnt"}, sv_cnt, e_resp - 1);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_selclr"}, 32'(sel), 32'd0);
  endtask

  task automatic run4(input string tag, input logic [31:0] a, input logic [3:0] ack_v,
                      input logic [3:0] e_sel, input logic [1:0] e_idx, input logic e_err);
    r2_addr = a;
    r2_valid = 1'b1;
    step();
    r2_valid = 1'b0;
    check({tag, "_sel"}, 32'(r2_sel), 32'(e_sel));
    check({tag, "_idx"}, 32'(r2_idx), 32'(e_idx));
    check({tag, "_slv"}, 32'(r2_slv_valid), 32'd1);
    r2_ack = ack_v;
    step();
    r2_ack = 4'b0;
    check({tag, "_resp"}, 32'(r2_resp_valid), 32'd1);
    check({tag, "_err"}, 32'(r2_resp_err), 32'(e_err));
    check({tag, "_slv2"}, 32'(r2_slv_valid), 32'd0);
    step();
    check({tag, "_ready"}, 32'(r2_ready), 32'd1);
  endtask

  initial begin
    int n_resp;
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_slv", 32'(slv_valid), 32'd0);
    check("rst_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    run("hit_2b10", 32'h2B10, 3, 2'b01, 2'b01, 1'b0, 4, 1'b0);
    run("hit_2f0f", 32'h2F0F, 3, 2'b01, 2'b01, 1'b0, 4, 1'b0);
    run("b_2b0f", 32'h2B0F, 1, 2'b10, 2'b10, 1'b1, 2, 1'b0);
    run("b_2f10", 32'h2F10, 2, 2'b10, 2'b10, 1'b1, 3, 1'b0);
    run("b_0", 32'h0000_0000, 1, 2'b10, 2'b10, 1'b1, 2, 1'b0);
    run("b_ffff", 32'h0000_FFFF, 5, 2'b10, 2'b10, 1'b1, 6, 1'b0);
    run("unmap", 32'h0001_0000, 0, 2'b00, 2'b00, 1'b0, 1, 1'b1);
    run("tmo", 32'h2C00, 0, 2'b00, 2'b01, 1'b0, 16, 1'b1);
    run("tmo_ack15", 32'h2C00, 15, 2'b01, 2'b01, 1'b0, 16, 1'b0);
    run("tmo_wrongack", 32'h2C00, 1, 2'b10, 2'b01, 1'b0, 16, 1'b1);

    req_addr = 32'h2C00;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    check("mid_busy", 32'(slv_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(req_ready), 32'd1);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_idx", 32'(region_idx), 32'd0);
    check("arst_slv", 32'(slv_valid), 32'd0);
    check("arst_resp", 32'(resp_valid), 32'd0);
    check("arst_err", 32'(resp_err), 32'd0);
    #2 rst = 1'b0;
    n_resp = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (resp_valid) n_resp++;
    end
    check("arst_noresp", n_resp, 0);

    req_addr = 32'h2B10;
    req_valid = 1'b1;
    step();
    req_addr = 32'h1000;
    slv_ack = 2'b01;
    step();
    slv_ack = 2'b00;
    check("b2b_resp1", 32'(resp_valid), 32'd1);
    check("b2b_err1", 32'(resp_err), 32'd0);
    step();
    check("b2b_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("b2b_slv2", 32'(slv_valid), 32'd1);
    check("b2b_sel2", 32'(sel), 32'd2);
    slv_ack = 2'b10;
    step();
    slv_ack = 2'b00;
    check("b2b_resp2", 32'(resp_valid), 32'd1);
    check("b2b_err2", 32'(resp_err), 32'd0);
    step();

    run4("r4_1800", 32'h1800, 4'b0010, 4'b0010, 2'd1, 1'b0);
    run4("r4_2000", 32'h2000, 4'b0000, 4'b0100, 2'd2, 1'b1);
    run4("r4_5000", 32'h5000, 4'b0001, 4'b0001, 2'd0, 1'b0);
    run4("r4_9000", 32'h9000, 4'b1000, 4'b1000, 2'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addr_router.md
# addr_router

Parametrised, registered address router for the CPU data bus. It decodes a request address against `N_REGIONS` programmable, inclusive address windows and forwards the request to exactly one slave with a one-hot select. It waits for that slave's acknowledge, with a bounded timeout, and returns a single-cycle response with an error flag. It sits between the CPU memory-access stage and the internal/external memories, and generalises the single-window internal/external chip-select decode.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `N_REGIONS`, 2, number of slave windows (≥1).
- `REGION_BASE`, {32'h0000_0000, 32'h0000_2B10}, packed `N_REGIONS*ADDR_W`; slice i = first address of region i.
- `REGION_LAST`, {32'h0000_FFFF, 32'h0000_2F0F}, packed; slice i = last address of region i (inclusive).
- `TIMEOUT`, 15, maximum cycles `slv_valid` stays high awaiting ack (≥1).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_addr`  in  ADDR_W  request address.
- `req_ready`  out  1  router can accept (high only in IDLE).
- `sel`  out  N_REGIONS  registered one-hot slave select.
- `region_idx`  out  $clog2(N_REGIONS) (min 1)  index of the selected region.
- `slv_valid`  out  1  request presented to the selected slave.
- `slv_ack`  in  N_REGIONS  per-slave acknowledge.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_err`  out  1  qualifies `resp_valid`: unmapped or timeout.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, decode `req_addr`: region i hits when BASE_i ≤ addr ≤ LAST_i (unsigned compare).
  - Overlap is resolved by the lowest index.
  - Hit: register `sel`=1<<i and `region_idx`=i, clear the counter, go to BUSY.
  - No hit: `sel`=0, set the error flag, go to RESP.
- **BUSY**
  - `slv_valid`=1, `req_ready`=0.
  - If `slv_ack[region_idx]`=1: clear the error flag, go to RESP.
  - Else if counter == TIMEOUT-1: set the error flag, go to RESP.
  - Otherwise increment the counter.
  - Acks on non-selected bits are ignored.
  - Counter width is $clog2(TIMEOUT+1).
- **RESP**
  - `resp_valid`=1 and `resp_err`=error flag for exactly one cycle.
  - `sel` is still held.
  - Go to IDLE. On that transition, `sel` clears to 0.
- `req_addr` is sampled only on acceptance. Later changes have no effect.
- Reset (async, any state, including mid-BUSY): state=IDLE, counter=0, `sel`=0, `region_idx`=0, `slv_valid`=0, `resp_valid`=0, `resp_err`=0. `req_ready` becomes 1 immediately.

## Timing
- Cycle 0 = the edge where `req_valid` and `req_ready` are both high.
- Mapped request: `sel` and `slv_valid` are high from cycle 1.
- Ack sampled high at edge k (k ≥ 1): `resp_valid` high during cycle k+1, `req_ready` back at cycle k+2.
  - Minimum round trip: ack in cycle 1 gives the response in cycle 2.
- Unmapped request: `resp_valid`=1, `resp_err`=1 in cycle 1, with `slv_valid` never asserted.
- Timeout: `slv_valid` is high for exactly TIMEOUT cycles (1..TIMEOUT), then the error response comes in cycle TIMEOUT+1.
  - An ack on the last BUSY cycle wins: response with no error.
- Back-to-back: `req_valid` held high is accepted again on the first IDLE edge. There is no combinational path from `req_valid` to any output except through state.

## Test plan
- Internal hit (defaults): `req_addr`=0x2B10, ack[0] on cycle 3 -> `sel`=2'b01 and `region_idx`=0 from cycle 1; `resp_valid`=1 with `resp_err`=0 in cycle 4. Repeat with 0x2F0F, same result.
- Overlap and boundaries: 0x2B0F and 0x2F10 -> `sel`=2'b10 (region 1); 0x0000_0000 -> region 1; 0x0000_FFFF -> region 1.
- Unmapped: 0x0001_0000 -> `resp_valid`=1 and `resp_err`=1 in cycle 1; `slv_valid` is never 1; `sel`=0.
- Timeout:
  - 0x2C00 with no ack -> `slv_valid` high for exactly 15 cycles; `resp_err`=1 in cycle 16.
  - Same, but ack[0] in cycle 15 -> `resp_err`=0 in cycle 16.
  - ack[1] pulses while region 0 is selected -> ignored.
- Reset mid-BUSY: assert `rst` asynchronously in cycle 5 of a pending request -> all outputs reset before the next edge; `req_ready`=1; no `resp_valid` after release.
- Back-to-back plus parameter sweep:
  - `req_valid` held high with 0x2B10 then 0x1000 -> second acceptance exactly in the first IDLE cycle after RESP.
  - Re-run with `N_REGIONS`=4 and `TIMEOUT`=1: single-cycle `slv_valid`; the lowest-index overlap winner is selected.
